// File: rtl/hilo_pkg.sv
// hilo_pkg: shared width, FSM state type and reset value for the HI/LO multiply unit.
package hilo_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [XLEN-1:0] HILO_RST = '0;

    // A LATENCY of 1 still needs a one-bit counter to hold the zero value.
    function automatic int cntWidth(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO pair with a product capture port that has
// priority over the independent direct-write port (MTHI/MTLO).
module hilo_regs
    import hilo_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cap_en_i,
    input  logic [XLEN-1:0] cap_hi_i,
    input  logic [XLEN-1:0] cap_lo_i,
    input  logic            wr_hi_en_i,
    input  logic            wr_lo_en_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_en_i) begin
            hi_d = cap_hi_i;
            lo_d = cap_lo_i;
        end else begin
            if (wr_hi_en_i) hi_d = wr_data_i;
            if (wr_lo_en_i) lo_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/hilo_mult_seq.sv
// hilo_mult_seq: valid/ready front end and HI/LO back end for the shared 32x32 multiplier.
// Define HILO_MULTU_EN to register req_unsigned into opnd_unsigned for MULTU support.
module hilo_mult_seq
    import hilo_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] opnd_a_o,
    output logic [XLEN-1:0] opnd_b_o,
    output logic            opnd_unsigned_o,
    input  logic [XLEN-1:0] mul_hi_i,
    input  logic [XLEN-1:0] mul_lo_i,
    input  logic            wr_hi_en_i,
    input  logic            wr_lo_en_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int CNT_W = cntWidth(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    generate
        if (LATENCY < 1) begin : gLatencyCheck
            $error("hilo_mult_seq: LATENCY must be at least 1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  opndA_q, opndA_d;
    logic [XLEN-1:0]  opndB_q, opndB_d;
    logic             done_q, done_d;
    logic             accept;
    logic             captureEn;
    logic             isIdle;

    // The counter is loaded with LATENCY-1 so capture lands exactly LATENCY edges after acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opndA_d   = opndA_q;
        opndB_d   = opndB_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        captureEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    opndA_d = op_a_i;
                    opndB_d = op_b_i;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    captureEn = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opndA_q <= HILO_RST;
            opndB_q <= HILO_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opndA_q <= opndA_d;
            opndB_q <= opndB_d;
            done_q  <= done_d;
        end
    end

`ifdef HILO_MULTU_EN
    logic opndUns_q, opndUns_d;

    assign opndUns_d = accept ? req_unsigned_i : opndUns_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            opndUns_q <= 1'b0;
        end else begin
            opndUns_q <= opndUns_d;
        end
    end

    assign opnd_unsigned_o = opndUns_q;
`else
    logic unusedReqUnsigned;

    // Without MULTU every request is signed; the select input is deliberately ignored.
    assign unusedReqUnsigned = req_unsigned_i ^ accept;
    assign opnd_unsigned_o   = 1'b0;
`endif

    assign isIdle = (state_q == IDLE);

    // Direct writes are only honoured in IDLE; a same-cycle capture always wins inside hilo_regs.
    hilo_regs uRegs (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .cap_en_i   (captureEn),
        .cap_hi_i   (mul_hi_i),
        .cap_lo_i   (mul_lo_i),
        .wr_hi_en_i (wr_hi_en_i & isIdle),
        .wr_lo_en_i (wr_lo_en_i & isIdle),
        .wr_data_i  (wr_data_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    assign req_ready_o = isIdle;
    assign busy_o      = ~isIdle;
    assign done_o      = done_q;
    assign opnd_a_o    = opndA_q;
    assign opnd_b_o    = opndB_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb_hilo_mult_seq: directed vectors with a product scoreboard for LATENCY=4 and LATENCY=1 instances,
// each fed by a behavioural signed/unsigned multiplier between opnd_* and mul_*.
module tb_hilo_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // LATENCY=4 instance signals
    logic        aRstN, aReqValid, aReqReady, aReqUns, aOpndUns;
    logic [31:0] aOpA, aOpB, aOpndA, aOpndB, aMulHi, aMulLo, aWrData, aHi, aLo;
    logic        aWrHiEn, aWrLoEn, aBusy, aDone;
    logic [63:0] aProd;

    // LATENCY=1 instance signals
    logic        bRstN, bReqValid, bReqReady, bReqUns, bOpndUns;
    logic [31:0] bOpA, bOpB, bOpndA, bOpndB, bMulHi, bMulLo, bWrData, bHi, bLo;
    logic        bWrHiEn, bWrLoEn, bBusy, bDone;
    logic [63:0] bProd;

    logic [63:0] aQueue[$];
    logic [63:0] bQueue[$];

    hilo_mult_seq #(.LATENCY(4)) dutA (
        .clk_i(clk), .rst_n_i(aRstN),
        .req_valid_i(aReqValid), .req_ready_o(aReqReady), .req_unsigned_i(aReqUns),
        .op_a_i(aOpA), .op_b_i(aOpB),
        .opnd_a_o(aOpndA), .opnd_b_o(aOpndB), .opnd_unsigned_o(aOpndUns),
        .mul_hi_i(aMulHi), .mul_lo_i(aMulLo),
        .wr_hi_en_i(aWrHiEn), .wr_lo_en_i(aWrLoEn), .wr_data_i(aWrData),
        .hi_o(aHi), .lo_o(aLo), .busy_o(aBusy), .done_o(aDone)
    );

    hilo_mult_seq #(.LATENCY(1)) dutB (
        .clk_i(clk), .rst_n_i(bRstN),
        .req_valid_i(bReqValid), .req_ready_o(bReqReady), .req_unsigned_i(bReqUns),
        .op_a_i(bOpA), .op_b_i(bOpB),
        .opnd_a_o(bOpndA), .opnd_b_o(bOpndB), .opnd_unsigned_o(bOpndUns),
        .mul_hi_i(bMulHi), .mul_lo_i(bMulLo),
        .wr_hi_en_i(bWrHiEn), .wr_lo_en_i(bWrLoEn), .wr_data_i(bWrData),
        .hi_o(bHi), .lo_o(bLo), .busy_o(bBusy), .done_o(bDone)
    );

    // Stand-in for the team's combinational signed/unsigned multiplier
    always_comb begin
        if (aOpndUns) aProd = {32'b0, aOpndA} * {32'b0, aOpndB};
        else          aProd = $signed({{32{aOpndA[31]}}, aOpndA}) * $signed({{32{aOpndB[31]}}, aOpndB});
        if (bOpndUns) bProd = {32'b0, bOpndA} * {32'b0, bOpndB};
        else          bProd = $signed({{32{bOpndA[31]}}, bOpndA}) * $signed({{32{bOpndB[31]}}, bOpndB});
    end
    assign aMulHi = aProd[63:32];
    assign aMulLo = aProd[31:0];
    assign bMulHi = bProd[63:32];
    assign bMulLo = bProd[31:0];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors pop the scoreboard whenever a done pulse shows a new product
    always @(negedge clk) begin
        if (aDone === 1'b1) begin
            if (aQueue.size() == 0) checkOutput("a_unexpected_done", 64'd1, 64'd0);
            else                    checkOutput("a_product", {aHi, aLo}, aQueue.pop_front());
        end
        if (bDone === 1'b1) begin
            if (bQueue.size() == 0) checkOutput("b_unexpected_done", 64'd1, 64'd0);
            else                    checkOutput("b_product", {bHi, bLo}, bQueue.pop_front());
        end
    end

    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic uns,
                                 input logic [63:0] expected);
        aReqValid = 1'b1;
        aOpA      = opA;
        aOpB      = opB;
        aReqUns   = uns;
        aQueue.push_back(expected);
        tick();
        aReqValid = 1'b0;
        aReqUns   = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        for (n = 0; n < 20; n++) begin
            if (aDone === 1'b1) break;
            tick();
        end
        if (n == 20) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aRstN = 1'b0; aReqValid = 1'b0; aReqUns = 1'b0; aOpA = '0; aOpB = '0;
        aWrHiEn = 1'b0; aWrLoEn = 1'b0; aWrData = '0;
        bRstN = 1'b0; bReqValid = 1'b0; bReqUns = 1'b0; bOpA = '0; bOpB = '0;
        bWrHiEn = 1'b0; bWrLoEn = 1'b0; bWrData = '0;
        tick();
        tick();
        checkOutput("rst_hilo", {aHi, aLo}, 64'h0);
        checkOutput("rst_ctrl", {61'd0, aBusy, aDone, aReqReady}, 64'd1);
        checkOutput("rst_opnd", {aOpndA, aOpndB}, 64'h0);
        aRstN = 1'b1;
        bRstN = 1'b1;
        tick();

        // -3 * 5 = -15, with busy for exactly four cycles
        applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("opnd_a_latched", {32'd0, aOpndA}, 64'h0000_0000_FFFF_FFFD);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("busy_c%0d", i), {62'd0, aBusy, aDone}, 64'd2);
            tick();
        end
        checkOutput("done_c5", {61'd0, aBusy, aDone, aReqReady}, 64'd3);

        // Back-to-back accept in the done cycle; a write during WAIT must be dropped
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        checkOutput("b2b_no_bubble", {62'd0, aBusy, aDone}, 64'd2);
        aWrHiEn = 1'b1;
        aWrData = 32'hDEAD_BEEF;
        tick();
        aWrHiEn = 1'b0;
        checkOutput("wait_write_dropped", {32'd0, aHi}, 64'h0000_0000_FFFF_FFFF);
        waitDone("b2b");
        checkOutput("capture_wins", {aHi, aLo}, 64'h0000_0001_0000_0000);

        // Direct writes in IDLE
        tick();
        aWrHiEn = 1'b1; aWrData = 32'hDEAD_BEEF;
        tick();
        aWrHiEn = 1'b0;
        checkOutput("mthi", {aHi, aLo}, 64'hDEAD_BEEF_0000_0000);
        aWrLoEn = 1'b1; aWrData = 32'h1234_5678;
        tick();
        checkOutput("mtlo", {aHi, aLo}, 64'hDEAD_BEEF_1234_5678);
        aWrHiEn = 1'b1; aWrData = 32'hCAFE_F00D;
        tick();
        aWrHiEn = 1'b0; aWrLoEn = 1'b0;
        checkOutput("mt_both", {aHi, aLo}, 64'hCAFE_F00D_CAFE_F00D);

        // Write in the accept cycle is applied, then overwritten by the capture
        aWrLoEn = 1'b1; aWrData = 32'h0000_0055;
        applyStimulus(32'd2, 32'd3, 1'b0, 64'h0000_0000_0000_0006);
        aWrLoEn = 1'b0;
        checkOutput("accept_write", {32'd0, aLo}, 64'h55);
        waitDone("accept_write");
        tick();

        // Reset in the second WAIT cycle abandons the multiply
        aReqValid = 1'b1; aOpA = 32'd9; aOpB = 32'd9;
        tick();
        aReqValid = 1'b0;
        tick();
        aRstN = 1'b0;
        tick();
        aRstN = 1'b1;
        checkOutput("midrst_hilo", {aHi, aLo}, 64'h0);
        checkOutput("midrst_ctrl", {61'd0, aBusy, aDone, aReqReady}, 64'd1);
        checkOutput("midrst_opnd", {aOpndA, aOpndB}, 64'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("midrst_no_done", {63'd0, aDone}, 64'd0);
        end

        // Unsigned select and further signed corner cases
`ifdef HILO_MULTU_EN
        applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE);
        checkOutput("opnd_unsigned", {63'd0, aOpndUns}, 64'd1);
`else
        applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("opnd_unsigned", {63'd0, aOpndUns}, 64'd0);
`endif
        waitDone("multu");
        applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 64'h0000_0000_0000_0006);
        waitDone("neg_neg");
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001);
        waitDone("max_pos");
        tick();

        // LATENCY=1 instance: done two cycles after acceptance, then back-to-back
        bReqValid = 1'b1; bOpA = 32'd7; bOpB = 32'd6;
        bQueue.push_back(64'd42);
        tick();
        bReqValid = 1'b0;
        checkOutput("lat1_c1", {62'd0, bBusy, bDone}, 64'd2);
        tick();
        checkOutput("lat1_c2", {62'd0, bBusy, bDone}, 64'd1);
        checkOutput("lat1_lo", {32'd0, bLo}, 64'd42);
        bReqValid = 1'b1; bOpA = 32'h0001_0000; bOpB = 32'd3;
        bQueue.push_back(64'h0000_0000_0003_0000);
        tick();
        bReqValid = 1'b0;
        tick();
        checkOutput("lat1_b2b_done", {63'd0, bDone}, 64'd1);
        tick();
        tick();

        checkOutput("a_queue_drained", 64'(aQueue.size()), 64'd0);
        checkOutput("b_queue_drained", 64'(bQueue.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_mult_seq.md
# hilo_mult_seq

Sequential front/back end for the team's combinational 32×32 multiplier. It accepts multiply requests through a valid/ready handshake and registers the operands that drive the multiplier. It holds them stable for a fixed multicycle window, then captures the 64-bit product into architectural HI/LO registers. It also services direct HI/LO writes (MTHI/MTLO) and provides HI/LO read data to the datapath.

## Interface
- LATENCY, 4: cycles operands are held stable before capture; legal range ≥1; LATENCY=0 is an elaboration error.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  multiply request.
- req_ready  out  1  block can accept a request this cycle.
- req_unsigned  in  1  request is MULTU; used only with HILO_MULTU_EN.
- op_a, op_b  in  32  multiplicand, multiplier.
- opnd_a, opnd_b  out  32  registered operands driven to the multiplier.
- opnd_unsigned  out  1  registered unsigned select to the multiplier; tied 0 without HILO_MULTU_EN.
- mul_hi, mul_lo  in  32  product returned from the multiplier.
- wr_hi_en, wr_lo_en  in  1  direct HI/LO write enables.
- wr_data  in  32  direct write data.
- hi, lo  out  32  architectural HI/LO.
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse: new product visible on hi/lo.

## Operation
- States: IDLE, WAIT.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid: latch op_a/op_b/req_unsigned into opnd_*, load cnt=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0, busy=1.
  - If cnt≠0: decrement cnt.
  - If cnt==0: hi<=mul_hi, lo<=mul_lo, done<=1, go to IDLE.
- Counter width is $clog2(LATENCY). Use 1 bit when LATENCY=1.
- opnd_* hold their value after capture until the next accepted request.
- Direct writes:
  - Applied only in IDLE; wr_hi_en loads hi, wr_lo_en loads lo, independently.
  - Both enables high writes wr_data to both.
  - Writes during WAIT are dropped.
  - A write in the same cycle a request is accepted is applied; the later capture overwrites it.
- Reset: all outputs and state reach 0/IDLE at the first clk edge with rst_n=0. This covers hi, lo, opnd_a, opnd_b, opnd_unsigned, done, busy and cnt. An in-flight multiply is abandoned with no capture and no done.

## Timing
- Request accepted at edge E; opnd_* valid from cycle E+1.
- Capture at edge E+LATENCY. hi/lo/done updated in cycle E+LATENCY+1; busy falls in the same cycle.
- Back-to-back: req_ready=1 in the done cycle, so a new request may be accepted there. Throughput is one product per LATENCY+1 cycles.
- hi/lo are register outputs with no combinational path from mul_* or wr_data.
- Multiplier paths opnd_*→mul_* are LATENCY-cycle multicycle paths in constraints.

## Configuration
- HILO_MULTU_EN defined:
  - req_unsigned is registered into opnd_unsigned; the multiplier selects its unsigned path.
  - An unsigned request with op_a=0xFFFFFFFF yields the unsigned product.
- Undefined:
  - req_unsigned is ignored; opnd_unsigned is constant 0; every request is signed.
  - No extra flop.

## Structure
- Package hilo_pkg:
  - XLEN=32.
  - State enum {IDLE, WAIT}.
  - Reset constant HILO_RST='0.
- Sub-module hilo_regs: HI/LO register pair with capture port (priority) and direct-write port, including synchronous reset.
- FSM, counter and operand registers live in the top block.

## Test plan
Bench places the team's signed/unsigned multiplier between opnd_* and mul_*.

- Reset, then LATENCY=4, op_a=-3, op_b=5 -> busy in cycles 1–4; hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 in cycle 5 only.
- Request accepted in the done cycle with op_a=0x10000, op_b=0x10000 -> next product hi=0x00000001, lo=0; no bubble cycle.
- wr_hi_en=1, wr_data=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. The same write during WAIT leaves hi unchanged, and the capture value wins.
- rst_n=0 in cycle 2 of WAIT -> next cycle hi=lo=0, busy=0, done stays 0, req_ready=1.
- HILO_MULTU_EN, req_unsigned=1, op_a=0xFFFFFFFF, op_b=2 -> hi=0x00000001, lo=0xFFFFFFFE. Without the macro the same stimulus gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- LATENCY=1, op_a=7, op_b=6 -> lo=42 and done in cycle 2 after acceptance.
